jstk2_spi_responder: RTL and testbench
======================================

# jstk2_spi_responder

SPI mode-0 responder: the device end of the joystick link whose initiator drives chip select, SCLK and MOSI. It samples the bus in the system clock domain and answers each 5-byte frame with a snapshot of X, Y and button state. It captures the 5 received bytes and reports frame completion or abort. It sits in the joystick IP as a loopback/emulation target for bench and on-board self-test of the master path.

## Interface
- SYNC_STAGES, 2: synchronizer flops on SCLK, CS and MOSI (min 2).
- LED_RESET, 24'h000000: reset/initial value of o_led_rgb.
- i_clk  in  1  system clock; must be ≥ 8× SCLK frequency.
- i_reset  in  1  asynchronous, active-high reset.
- i_sclk  in  1  SPI clock from initiator, asynchronous to i_clk.
- i_cs  in  1  chip select, active low, asynchronous.
- i_mosi  in  1  initiator data out.
- o_miso  out  1  responder data out.
- o_miso_oe  out  1  MISO output enable, high while frame active.
- i_x  in  10  joystick X sample.
- i_y  in  10  joystick Y sample.
- i_buttons  in  2  {trigger, stick} buttons.
- o_rx_frame  out  40  last complete received frame; byte 0 in [39:32].
- o_led_rgb  out  24  {R,G,B} from last set-LED command.
- o_frame_done  out  1  one-cycle pulse, complete frame accepted.
- o_frame_err  out  1  one-cycle pulse, frame aborted (CS rose with bit count ≠ 40).
- o_busy  out  1  high from CS fall seen to CS rise seen.

## Operation
- Input path: SYNC_STAGES-flop synchronizer on i_sclk, i_cs, i_mosi; rise/fall detect on synced SCLK and CS. MOSI is sampled from the same synced stage as SCLK.
- States: IDLE, ACTIVE, OVERRUN.
- IDLE → ACTIVE on synced CS fall. Actions:
  - snapshot TX register = {i_x[7:0], 6'b0,i_x[9:8], i_y[7:0], 6'b0,i_y[9:8], 6'b0,i_buttons};
  - clear bit counter (6 bits);
  - drive TX MSB on o_miso; set o_miso_oe and o_busy.
- ACTIVE, synced SCLK rise: shift MOSI into RX register (MSB first); increment counter.
- ACTIVE, synced SCLK fall: shift TX left; o_miso = new MSB.
- Counter reaches 40 → OVERRUN. Further SCLK edges are ignored. o_miso = 0. Counter saturates.
- CS rise in ACTIVE or OVERRUN → IDLE. o_miso_oe = 0, o_busy = 0, o_miso = 0.
  - Counter == 40: o_rx_frame ← RX; pulse o_frame_done.
  - Counter ≠ 40: o_rx_frame and o_led_rgb unchanged; pulse o_frame_err.
  - CS rise with zero SCLK edges is an error frame.
- SCLK edges while in IDLE are ignored. Simultaneous CS rise and SCLK edge in the same cycle: CS wins; the edge is dropped.
- Inputs i_x/i_y/i_buttons may change mid-frame; only the CS-fall snapshot is transmitted.
- Async reset mid-frame: all state to reset values. The block stays IDLE until the next synced CS fall, so a frame already in progress is ignored.

## Timing
- Bus event to internal action: SYNC_STAGES+1 i_clk cycles.
- o_miso first bit valid SYNC_STAGES+1 cycles after CS fall. The initiator must hold ≥ SYNC_STAGES+3 i_clk between CS fall and first SCLK rise.
- o_frame_done/o_frame_err assert SYNC_STAGES+1 cycles after CS rise, for exactly 1 cycle. o_rx_frame and o_led_rgb update in that same cycle.
- Reset values: o_miso 0, o_miso_oe 0, o_busy 0, o_frame_done 0, o_frame_err 0, o_rx_frame 0, o_led_rgb LED_RESET. State is IDLE and counter is 0.

## Configuration
- JSTK2_RSP_LED_CMD_EN defined:
  - on o_frame_done, if byte 0 == 8'h84, o_led_rgb ← bytes 1..3 as {R,G,B}; byte 4 is ignored;
  - any other command byte leaves o_led_rgb unchanged.
- Undefined: no command decode. o_led_rgb is constant LED_RESET. Frame capture and MISO reply are unchanged.

## Structure
- jstk2_pkg holds:
  - state enum (IDLE, ACTIVE, OVERRUN);
  - FRAME_BITS = 40;
  - CMD_SET_LED = 8'h84;
  - TX frame packing function.
- One sub-module, spi_input_sync: parameterized synchronizer plus rise/fall edge detect for SCLK and CS. It outputs synced MOSI, sclk_rise, sclk_fall, cs_fall and cs_rise.

## Test plan
- Reset, then idle 10 cycles → all outputs at reset values, o_led_rgb = LED_RESET.
- i_x=10'h2A5, i_y=10'h13C, i_buttons=2'b10; 40-bit frame of 8'h84,8'h11,8'h22,8'h33,8'h00 at i_clk/16 → MISO bytes 8'hA5,8'h02,8'h3C,8'h01,8'h02. o_rx_frame=40'h8411223300. o_frame_done pulses once. o_led_rgb=24'h112233 with the macro, LED_RESET without.
- CS raised after 17 bits → o_frame_err pulses once. o_rx_frame and o_led_rgb hold their previous values.
- 48 SCLK cycles in one frame → bits 41–48 are ignored, o_miso=0 after bit 40. Frame accepted with the first 40 bits.
- i_x changed mid-frame from 10'h2A5 to 10'h000 → MISO still sends 8'hA5,8'h02.
- Async reset asserted at bit 20, released, then CS raised → no pulses. Next full frame is accepted normally.

Source files
------------

// File: rtl/jstk2_pkg.sv
// Shared types and constants for the joystick SPI responder: FSM states,
// frame length, command codes and the reply-frame packing.
package jstk2_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        OVERRUN = 2'd2
    } state_t;

    localparam int          FRAME_BITS  = 40;
    localparam logic [7:0]  CMD_SET_LED = 8'h84;

    // Reply bytes in transmit order: X low, X high, Y low, Y high, buttons.
    function automatic logic [39:0] pack_tx(input logic [9:0] x,
                                            input logic [9:0] y,
                                            input logic [1:0] buttons);
        return {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 6'b0, buttons};
    endfunction

endpackage

// File: rtl/jstk2_spi_responder_spi_input_sync.sv
// Synchronizes SCLK, CS and MOSI into the system clock domain and produces
// single-cycle edge strobes for SCLK and CS.
module spi_input_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic sclk,
    input  logic cs,
    input  logic mosi,
    output logic mosi_sync,
    output logic sclk_rise,
    output logic sclk_fall,
    output logic cs_fall,
    output logic cs_rise
);

    logic [SYNC_STAGES-1:0] sclk_sr;
    logic [SYNC_STAGES-1:0] cs_sr;
    logic [SYNC_STAGES-1:0] mosi_sr;
    logic                   sclk_prev;
    logic                   cs_prev;

    // CS resets low so a frame already running when reset drops is never
    // mistaken for a fresh CS fall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sr   <= '0;
            cs_sr     <= '0;
            mosi_sr   <= '0;
            sclk_prev <= 1'b0;
            cs_prev   <= 1'b0;
        end else begin
            sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], sclk};
            cs_sr     <= {cs_sr[SYNC_STAGES-2:0], cs};
            mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], mosi};
            sclk_prev <= sclk_sr[SYNC_STAGES-1];
            cs_prev   <= cs_sr[SYNC_STAGES-1];
        end
    end

    assign mosi_sync = mosi_sr[SYNC_STAGES-1];
    assign sclk_rise =  sclk_sr[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sr[SYNC_STAGES-1] &  sclk_prev;
    assign cs_fall   = ~cs_sr[SYNC_STAGES-1]   &  cs_prev;
    assign cs_rise   =  cs_sr[SYNC_STAGES-1]   & ~cs_prev;

endmodule

// File: rtl/jstk2_spi_responder.sv
// SPI mode-0 responder answering 5-byte frames with an X/Y/button snapshot.
// Define JSTK2_RSP_LED_CMD_EN to decode the set-LED command into o_led_rgb.
module jstk2_spi_responder
    import jstk2_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [23:0] LED_RESET   = 24'h000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_sclk,
    input  logic        i_cs,
    input  logic        i_mosi,
    output logic        o_miso,
    output logic        o_miso_oe,
    input  logic [9:0]  i_x,
    input  logic [9:0]  i_y,
    input  logic [1:0]  i_buttons,
    output logic [39:0] o_rx_frame,
    output logic [23:0] o_led_rgb,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic        o_busy
);

    logic mosi_sync, sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk       (i_clk),
        .rst       (i_reset),
        .sclk      (i_sclk),
        .cs        (i_cs),
        .mosi      (i_mosi),
        .mosi_sync (mosi_sync),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .cs_fall   (cs_fall),
        .cs_rise   (cs_rise)
    );

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [39:0] tx_q, tx_d;
    logic [39:0] rx_q, rx_d;
    logic [39:0] frame_d;
    logic        miso_d, oe_d, busy_d, done_d, err_d;
    logic        end_frame;
    logic [23:0] led_q, led_d;
    logic [39:0] tx_snap;

    assign tx_snap = pack_tx(i_x, i_y, i_buttons);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        frame_d   = o_rx_frame;
        miso_d    = o_miso;
        oe_d      = o_miso_oe;
        busy_d    = o_busy;
        done_d    = 1'b0;
        err_d     = 1'b0;
        led_d     = led_q;
        end_frame = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d = ACTIVE;
                    tx_d    = tx_snap;
                    cnt_d   = '0;
                    miso_d  = tx_snap[39];
                    oe_d    = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ACTIVE: begin
                // CS rise takes priority over any SCLK edge in the same cycle.
                if (cs_rise) begin
                    end_frame = 1'b1;
                end else if (sclk_rise) begin
                    rx_d  = {rx_q[38:0], mosi_sync};
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q + 6'd1 == 6'(FRAME_BITS)) begin
                        state_d = OVERRUN;
                        miso_d  = 1'b0;
                    end
                end else if (sclk_fall) begin
                    tx_d   = {tx_q[38:0], 1'b0};
                    miso_d = tx_q[38];
                end
            end
            OVERRUN: begin
                if (cs_rise) end_frame = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        if (end_frame) begin
            state_d = IDLE;
            oe_d    = 1'b0;
            busy_d  = 1'b0;
            miso_d  = 1'b0;
            if (cnt_q == 6'(FRAME_BITS)) begin
                frame_d = rx_q;
                done_d  = 1'b1;
                if (rx_q[39:32] == CMD_SET_LED) led_d = rx_q[31:8];
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            o_rx_frame   <= '0;
            o_miso       <= 1'b0;
            o_miso_oe    <= 1'b0;
            o_busy       <= 1'b0;
            o_frame_done <= 1'b0;
            o_frame_err  <= 1'b0;
            led_q        <= LED_RESET;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            o_rx_frame   <= frame_d;
            o_miso       <= miso_d;
            o_miso_oe    <= oe_d;
            o_busy       <= busy_d;
            o_frame_done <= done_d;
            o_frame_err  <= err_d;
            led_q        <= led_d;
        end
    end

`ifdef JSTK2_RSP_LED_CMD_EN
    assign o_led_rgb = led_q;
`else
    // Without command decode the LED register is never driven out.
    assign o_led_rgb = LED_RESET;
`endif

endmodule

// File: tb/tb_jstk2_spi_responder.sv
// Self-checking bench for jstk2_spi_responder: an SPI initiator driver, a
// frame-event scoreboard fed by a byte-level reference model, and a summary.
module tb_jstk2_spi_responder;

    localparam logic [23:0] LED_RESET = 24'h000000;
    localparam int          EW        = 66;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_sclk, i_cs, i_mosi;
    logic        o_miso, o_miso_oe;
    logic [9:0]  i_x, i_y;
    logic [1:0]  i_buttons;
    logic [39:0] o_rx_frame;
    logic [23:0] o_led_rgb;
    logic        o_frame_done, o_frame_err, o_busy;

    jstk2_spi_responder #(.SYNC_STAGES(2), .LED_RESET(LED_RESET)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_sclk       (i_sclk),
        .i_cs         (i_cs),
        .i_mosi       (i_mosi),
        .o_miso       (o_miso),
        .o_miso_oe    (o_miso_oe),
        .i_x          (i_x),
        .i_y          (i_y),
        .i_buttons    (i_buttons),
        .o_rx_frame   (o_rx_frame),
        .o_led_rgb    (o_led_rgb),
        .o_frame_done (o_frame_done),
        .o_frame_err  (o_frame_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Expected frame events: {done, err, rx_frame, led_rgb}.
    logic [EW-1:0] exp_q[$];
    logic [39:0]   model_rx  = '0;
    logic [23:0]   model_led = LED_RESET;

    task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Monitor: every done/err pulse must match the oldest expected event.
    always @(negedge i_clk) begin
        if (!i_reset && (o_frame_done || o_frame_err)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse done=%0b err=%0b rx=%0h", o_frame_done, o_frame_err, o_rx_frame);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                if ({o_frame_done, o_frame_err, o_rx_frame, o_led_rgb} !== e) begin
                    errors++;
                    $display("FAIL frame_event got=%0h expected=%0h",
                             {o_frame_done, o_frame_err, o_rx_frame, o_led_rgb}, e);
                end
            end
        end
    end

    // One initiator frame. bits[47-i] is MOSI bit i; the MISO bits seen at
    // each SCLK rise are returned in the same positions.
    task automatic run_frame(input logic [47:0] bits, input int nbits, input int half,
                             input bit cs_with_rise, input int reset_at, input int change_x_at,
                             output logic [47:0] cap);
        logic [39:0]   txv;
        logic [47:0]   exp_miso;
        int            rises, xv, yv;
        bit            was_reset;
        logic [EW-1:0] ev;
        xv  = int'(i_x);
        yv  = int'(i_y);
        txv = {8'(xv % 256), 8'(xv / 256), 8'(yv % 256), 8'(yv / 256), 8'(i_buttons)};
        cap = '0;
        exp_miso = '0;
        rises = 0;
        was_reset = 0;

        @(negedge i_clk);
        i_cs = 1'b0;
        repeat (8) @(negedge i_clk);
        check("busy_oe_active", EW'({o_busy, o_miso_oe}), EW'(2'b11));

        for (int i = 0; i < nbits; i++) begin
            if (i == reset_at) begin
                i_reset = 1'b1;
                repeat (3) @(negedge i_clk);
                i_reset = 1'b0;
                model_rx  = '0;
                model_led = LED_RESET;
                was_reset = 1;
                break;
            end
            if (i == change_x_at) i_x = '0;
            i_mosi = bits[47-i];
            repeat (half) @(negedge i_clk);
            i_sclk = 1'b1;
            if (cs_with_rise && i == nbits - 1) begin
                i_cs = 1'b1;
                break;
            end
            cap[47-i] = o_miso;
            rises++;
            repeat (half) @(negedge i_clk);
            i_sclk = 1'b0;
        end

        if (!was_reset) begin
            if (rises >= 40) begin
                model_rx = bits[47:8];
`ifdef JSTK2_RSP_LED_CMD_EN
                if (model_rx[39:32] == 8'h84) model_led = model_rx[31:8];
`endif
                ev = {2'b10, model_rx, model_led};
            end else begin
                ev = {2'b01, model_rx, model_led};
            end
            exp_q.push_back(ev);
        end

        repeat (half) @(negedge i_clk);
        i_cs   = 1'b1;
        repeat (half) @(negedge i_clk);
        i_sclk = 1'b0;
        i_mosi = 1'b0;

        if (!was_reset) begin
            for (int i = 0; i < rises; i++)
                exp_miso[47-i] = (i < 40) ? txv[39-i] : 1'b0;
            check("miso_bits", EW'(cap), EW'(exp_miso));
        end

        for (int k = 0; k < 30 && exp_q.size() != 0; k++) @(negedge i_clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL frame_event_timeout pending=%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(negedge i_clk);
        check("idle_outputs", EW'({o_busy, o_miso_oe, o_miso}), EW'(3'b000));
        if (was_reset)
            check("after_reset", EW'({o_rx_frame, o_led_rgb}), EW'({40'h0, LED_RESET}));
    endtask

    initial begin
        logic [47:0] cap;
        logic [47:0] bits;
        int          nb, sel;

        i_reset = 1'b1;
        i_sclk = 1'b0; i_cs = 1'b1; i_mosi = 1'b0;
        i_x = '0; i_y = '0; i_buttons = '0;
        repeat (5) @(negedge i_clk);
        i_reset = 1'b0;
        repeat (10) @(negedge i_clk);
        check("rst_miso",   EW'(o_miso),       EW'(1'b0));
        check("rst_oe",     EW'(o_miso_oe),    EW'(1'b0));
        check("rst_busy",   EW'(o_busy),       EW'(1'b0));
        check("rst_done",   EW'(o_frame_done), EW'(1'b0));
        check("rst_err",    EW'(o_frame_err),  EW'(1'b0));
        check("rst_frame",  EW'(o_rx_frame),   EW'(40'h0));
        check("rst_led",    EW'(o_led_rgb),    EW'(LED_RESET));

        // Nominal frame at i_clk/16 carrying a set-LED command.
        i_x = 10'h2A5; i_y = 10'h13C; i_buttons = 2'b10;
        run_frame({40'h8411223300, 8'h00}, 40, 8, 0, -1, -1, cap);
        check("miso_bytes_nominal", EW'(cap[47:8]), EW'(40'hA5023C0102));

        // Short frame: 17 bits then CS rise.
        run_frame({40'h8455667788, 8'h00}, 17, 8, 0, -1, -1, cap);

        // 48 clocks: extra bits ignored, MISO low after bit 40.
        run_frame({40'h84AABBCC01, 8'hFF}, 48, 8, 0, -1, -1, cap);

        // X changes mid-frame; reply keeps the CS-fall snapshot.
        i_x = 10'h2A5;
        run_frame({40'h0102030405, 8'h00}, 40, 8, 0, -1, 4, cap);
        check("miso_x_snapshot", EW'(cap[47:32]), EW'(16'hA502));

        // CS rise with no SCLK edges.
        run_frame(48'h0, 0, 8, 0, -1, -1, cap);

        // 40th SCLK rise lands together with CS rise and is dropped.
        run_frame({40'h84DEADBE00, 8'h00}, 40, 6, 1, -1, -1, cap);

        // Reset at bit 20, then a normal frame.
        run_frame({40'h84CAFE0000, 8'h00}, 40, 8, 0, 20, -1, cap);
        i_x = 10'h155; i_y = 10'h3FF; i_buttons = 2'b01;
        run_frame({40'h84102030FF, 8'h00}, 40, 4, 0, -1, -1, cap);

        for (int n = 0; n < 24; n++) begin
            i_x       = 10'($urandom_range(0, 1023));
            i_y       = 10'($urandom_range(0, 1023));
            i_buttons = 2'($urandom_range(0, 3));
            bits      = {16'($urandom), 32'($urandom)};
            if ($urandom_range(0, 1) == 1) bits[47:40] = 8'h84;
            sel = $urandom_range(0, 3);
            nb  = (sel == 1) ? $urandom_range(41, 48) :
                  (sel == 2) ? $urandom_range(0, 39) : 40;
            run_frame(bits, nb, $urandom_range(4, 8), 0, -1, -1, cap);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
